// File: rtl/pattern_loader.sv
// rtl/pattern_loader.sv - UART-fed writer for the LED pattern memory
//
// Receives 8N1 bytes on rxd, waits for SYNC_BYTE, then writes the next DEPTH
// bytes (low DATA_W bits) to pattern-RAM addresses 0..DEPTH-1.
//
// Optional feature macro: PATTERN_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the DEPTH data bytes. It must equal
//   the 8-bit XOR of those data bytes for done to pulse.
//
// Ports:
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   rxd       in   UART serial input, idle high, asynchronous to clk
//   wr_en     out  one-cycle write strobe to pattern RAM
//   wr_addr   out  [AW-1:0] write address, valid with wr_en
//   wr_data   out  [DATA_W-1:0] write data, valid with wr_en
//   busy      out  high from accepted sync byte until the load ends
//   done      out  one-cycle pulse on successful load completion
//   frame_err out  sticky error flag, cleared by the next accepted sync byte
module pattern_loader #(
  parameter int         CLKS_PER_BIT = 87,
  parameter int         DEPTH        = 21,
  parameter int         AW           = 5,
  parameter int         DATA_W       = 5,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rxd,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  localparam logic [1:0] LD_WAIT_SYNC = 2'd0;
  localparam logic [1:0] LD_LOAD      = 2'd1;
`ifdef PATTERN_LOADER_CHECKSUM_EN
  localparam logic [1:0] LD_CHECK     = 2'd2;
`endif

  localparam logic [15:0]   BIT_END   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   HALF_END  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Input synchronizer; both flops reset to the idle level.
  logic r_rxd_meta;
  logic r_rxd_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // UART receiver
  logic [2:0]  r_rx_state;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_rx_valid;
  logic        r_rx_ferr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rxd_sync) begin
            r_rx_state <= RX_START;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_clk_cnt == HALF_END) begin
            r_clk_cnt  <= '0;
            // A line already back high at mid-start was a glitch.
            r_rx_state <= r_rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == BIT_END) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rxd_sync, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == BIT_END) begin
            r_clk_cnt <= '0;
            if (r_rxd_sync) begin
              r_rx_valid <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_ferr  <= 1'b1;
              r_rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        RX_WAIT_HIGH: begin
          // A held-low break must not be taken as a stream of start bits.
          if (r_rxd_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader; r_shift holds the received byte while r_rx_valid is high.
  logic [1:0]        r_ld_state;
  logic [AW-1:0]     r_addr;
  logic              r_wr_en;
  logic [AW-1:0]     r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_frame_err;
`ifdef PATTERN_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`else
  logic              r_last_wr;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ld_state  <= LD_WAIT_SYNC;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef PATTERN_LOADER_CHECKSUM_EN
      r_xor       <= '0;
`else
      r_last_wr   <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_ld_state)
        LD_WAIT_SYNC: begin
          if (r_rx_valid && (r_shift == SYNC_BYTE)) begin
            r_ld_state  <= LD_LOAD;
            r_addr      <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b1;
`ifdef PATTERN_LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
          end
        end
        LD_LOAD: begin
          if (r_rx_ferr) begin
            // Slot stays open for the next good byte.
            r_frame_err <= 1'b1;
          end else if (r_rx_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= r_shift[DATA_W-1:0];
`ifdef PATTERN_LOADER_CHECKSUM_EN
            r_xor     <= r_xor ^ r_shift;
            if (r_addr == LAST_ADDR) r_ld_state <= LD_CHECK;
            else                     r_addr     <= r_addr + 1'b1;
`else
            if (r_addr == LAST_ADDR) r_last_wr <= 1'b1;
            else                     r_addr    <= r_addr + 1'b1;
`endif
          end
        end
`ifdef PATTERN_LOADER_CHECKSUM_EN
        LD_CHECK: begin
          if (r_rx_ferr) begin
            r_frame_err <= 1'b1;
          end else if (r_rx_valid) begin
            if ((r_shift == r_xor) && !r_frame_err) r_done      <= 1'b1;
            else                                    r_frame_err <= 1'b1;
            r_busy     <= 1'b0;
            r_ld_state <= LD_WAIT_SYNC;
          end
        end
`endif
        default: r_ld_state <= LD_WAIT_SYNC;
      endcase
`ifndef PATTERN_LOADER_CHECKSUM_EN
      // Close the load the cycle after the final write strobe.
      if (r_last_wr) begin
        r_last_wr  <= 1'b0;
        r_done     <= !r_frame_err;
        r_busy     <= 1'b0;
        r_ld_state <= LD_WAIT_SYNC;
      end
`endif
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_pattern_loader.sv
// tb/tb_pattern_loader.sv - self-checking bench for pattern_loader
module tb_pattern_loader;

  localparam int         C     = 4;
  localparam int         DEPTH = 21;
  localparam int         AW    = 5;
  localparam int         DW    = 5;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rxd = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          frame_err;

  pattern_loader #(
    .CLKS_PER_BIT(C),
    .DEPTH(DEPTH),
    .AW(AW),
    .DATA_W(DW),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rxd(rxd),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observations from the DUT
  logic [9:0] obs_q[$];
  int done_cnt = 0;
  int last_wr_cyc = -100;
  int first_wr_cyc = -1;
  int bad_busy = 0;
  int bad_done_timing = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      if (obs_q.size() == 0) first_wr_cyc = cyc;
      obs_q.push_back({wr_addr, wr_data});
      last_wr_cyc = cyc;
      if (!busy) bad_busy++;
    end
    if (done) begin
      done_cnt++;
      if (cyc != last_wr_cyc + 1) bad_done_timing++;
      if (busy) bad_busy++;
    end
  end

  // Reference model: byte-level loader rules
  logic [9:0] exp_q[$];
  int exp_done = 0;
  bit m_loading = 1'b0;
  int m_addr = 0;
  bit m_ferr = 1'b0;

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      if (m_loading) m_ferr = 1'b1;
    end else if (!m_loading) begin
      if (b == SYNC) begin
        m_loading = 1'b1;
        m_addr = 0;
        m_ferr = 1'b0;
      end
    end else begin
      exp_q.push_back({5'(m_addr), b[4:0]});
      if (m_addr == DEPTH - 1) begin
        m_loading = 1'b0;
        if (!m_ferr) exp_done++;
      end else begin
        m_addr++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int last_start_cyc = 0;

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    last_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    model_byte(b, stop_ok);
  endtask

  task automatic check_phase(input string tag);
    int n;
    chk($sformatf("%s_nwr", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk($sformatf("%s_done", tag), 32'(done_cnt), 32'(exp_done));
    chk($sformatf("%s_busy", tag), 32'(busy), 32'(m_loading));
    chk($sformatf("%s_ferr", tag), 32'(frame_err), 32'(m_ferr));
    chk($sformatf("%s_busy_viol", tag), 32'(bad_busy), 32'd0);
    chk($sformatf("%s_done_timing", tag), 32'(bad_done_timing), 32'd0);
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0;
    exp_done = 0;
    first_wr_cyc = -1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk($sformatf("%s_wr_en", tag), 32'(wr_en), 32'd0);
    chk($sformatf("%s_wr_addr", tag), 32'(wr_addr), 32'd0);
    chk($sformatf("%s_wr_data", tag), 32'(wr_data), 32'd0);
    chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_done", tag), 32'(done), 32'd0);
    chk($sformatf("%s_frame_err", tag), 32'(frame_err), 32'd0);
  endtask

  initial begin
    int t_first;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    resetn = 1'b1;
    idle(5);

    // Directed load 0x00..0x14 plus first-write latency
    send_byte(SYNC, 1'b1);
    t_first = 0;
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 0) t_first = last_start_cyc;
    end
    idle(10);
    chk("latency", 32'(first_wr_cyc - t_first), 32'(2 + C / 2 + 9 * C + 2));
    chk("load1_done_count", 32'(done_cnt), 32'd1);
    check_phase("load1");

    // Junk bytes before sync, random data with a sync value inside the load
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(10);
    chk("junk_nwr", 32'(obs_q.size()), 32'd0);
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      b = (i == 3) ? SYNC : 8'($urandom_range(0, 255));
      send_byte(b, 1'b1);
    end
    idle(10);
    check_phase("load2");

    // Framing error on data byte 5
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i == 5) begin
        send_byte(b, 1'b0);
        idle(2 * C);
      end else begin
        send_byte(b, 1'b1);
      end
    end
    idle(10);
    check_phase("ferr");

    // One-cycle glitch while idle
    rxd = 1'b0;
    @(posedge clk);
    #1;
    idle(20);
    check_phase("glitch");

    // Reset in the middle of a load, then a fresh load
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(6);
    check_phase("mid");
    resetn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    m_loading = 1'b0;
    m_addr = 0;
    m_ferr = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(5);
    send_byte(8'($urandom_range(0, 255)) & 8'h7F, 1'b1);
    idle(10);
    chk("nosync_after_reset_nwr", 32'(obs_q.size()), 32'd0);
    send_byte(SYNC, 1'b1);
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle(10);
    check_phase("reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
